// File: rtl/traffic_phase_timer.sv
// ---------------------------------------------------------------------------
// traffic_phase_timer
//
// Upstream timing stage for the traffic light FSM. It holds each light phase
// for a configurable number of prescaled ticks, then issues a one-cycle
// advance pulse that the light FSM uses as its step enable. The light FSM's
// one-hot output is fed back so the timer knows which phase it is timing and
// can detect an FSM that fails to step.
//
// Pedestrian requests are edge-detected and held pending. A pending request
// cuts a long GREEN down to MIN_GREEN ticks and is acknowledged when the next
// RED phase is loaded.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous reset, active-high
//   light      in   3    current light from FSM: RED=100, GREEN=010, YELLOW=001
//   ped_req    in   1    pedestrian button level, rising edge registers a request
//   advance    out  1    one-cycle step pulse to the light FSM
//   ped_ack    out  1    one-cycle pulse when a pending request is served
//   remaining  out  CW   ticks left in the current phase
//   err        out  1    sticky: light did not change within WAIT_MAX cycles
// ---------------------------------------------------------------------------
module traffic_phase_timer #(
    parameter int PRESCALE     = 50,
    parameter int RED_TICKS    = 10,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int MIN_GREEN    = 3,
    parameter int WAIT_MAX     = 4,
    parameter int CW           = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    light,
    input  logic          ped_req,
    output logic          advance,
    output logic          ped_ack,
    output logic [CW-1:0] remaining,
    output logic          err
);

    localparam int PW = $clog2(PRESCALE);
    localparam int WW = $clog2(WAIT_MAX + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(WAIT_MAX);

    localparam logic [CW-1:0] RED_CNT       = CW'(RED_TICKS);
    localparam logic [CW-1:0] GREEN_CNT     = CW'(GREEN_TICKS);
    localparam logic [CW-1:0] YELLOW_CNT    = CW'(YELLOW_TICKS);
    localparam logic [CW-1:0] MIN_GREEN_CNT = CW'(MIN_GREEN);

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b010;
    localparam logic [2:0] LIGHT_YELLOW = 3'b001;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_COUNT,
        ST_ADV,
        ST_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [2:0]    light_q, light_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          pend_q, pend_d;
    logic          ped_req_q;
    logic          err_q, err_d;

    logic tick;
    logic shorten;
    logic load;
    logic serve;
    logic req_rise;

    // Phase length for the light being loaded. Anything that is not a clean
    // one-hot code is treated as RED so a glitching FSM fails safe.
    function automatic logic [CW-1:0] phaseTicks(input logic [2:0] code);
        case (code)
            LIGHT_RED:    phaseTicks = RED_CNT;
            LIGHT_GREEN:  phaseTicks = GREEN_CNT;
            LIGHT_YELLOW: phaseTicks = YELLOW_CNT;
            default:      phaseTicks = RED_CNT;
        endcase
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            presc_q     <= '0;
            remaining_q <= '0;
            light_q     <= '0;
            wait_q      <= '0;
            pend_q      <= 1'b0;
            ped_req_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            remaining_q <= remaining_d;
            light_q     <= light_d;
            wait_q      <= wait_d;
            pend_q      <= pend_d;
            ped_req_q   <= ped_req;
            err_q       <= err_d;
        end
    end

    // Next-state logic. The prescaler only runs in COUNT, so it naturally sits
    // at zero in every other state (the final tick of a phase clears it).
    // A pending pedestrian request restarts the tick grid when it shortens
    // GREEN, and takes priority over a tick landing in the same cycle.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        remaining_d = remaining_q;
        light_d     = light_q;
        wait_d      = wait_q;
        err_d       = err_q;
        load        = 1'b0;

        tick     = (presc_q == PRESC_LAST);
        shorten  = pend_q && (light == LIGHT_GREEN) && (remaining_q > MIN_GREEN_CNT);
        req_rise = ped_req && !ped_req_q;

        case (state_q)
            ST_SYNC: begin
                load    = 1'b1;
                state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (shorten) begin
                    remaining_d = MIN_GREEN_CNT;
                    presc_d     = '0;
                end else if (tick) begin
                    presc_d     = '0;
                    remaining_d = remaining_q - CW'(1);
                    if (remaining_q == CW'(1)) begin
                        state_d = ST_ADV;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_ADV: begin
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (light != light_q) begin
                    load    = 1'b1;
                    state_d = ST_COUNT;
                end else if ((wait_q + WW'(1)) == WAIT_LIMIT) begin
                    // The FSM never stepped: flag it, but keep timing so the
                    // intersection does not freeze.
                    err_d   = 1'b1;
                    load    = 1'b1;
                    state_d = ST_COUNT;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        if (load) begin
            remaining_d = phaseTicks(light);
            presc_d     = '0;
            light_d     = light;
        end

        // A new button edge on the serving cycle must not be lost, so the set
        // is applied after the clear.
        serve  = load && (light == LIGHT_RED) && pend_q;
        pend_d = pend_q;
        if (serve) begin
            pend_d = 1'b0;
        end
        if (req_rise) begin
            pend_d = 1'b1;
        end
    end

    // Outputs.
    always_comb begin
        advance   = (state_q == ST_ADV);
        ped_ack   = serve;
        remaining = remaining_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_timer
//
// Drives traffic_phase_timer with a small light-FSM model that steps
// RED->GREEN->YELLOW->RED one cycle after each advance pulse, plus
// pedestrian presses and resets. Expected pulses and per-cycle values come
// from a deadline-based reference model and are checked by a monitor.
// ---------------------------------------------------------------------------
module tb_traffic_phase_timer;

    localparam int P  = 4;
    localparam int RT = 3;
    localparam int GT = 4;
    localparam int YT = 2;
    localparam int MG = 1;
    localparam int WM = 4;
    localparam int CW = 16;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b001;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    light;
    logic          ped_req;
    logic          advance;
    logic          ped_ack;
    logic [CW-1:0] remaining;
    logic          err;

    traffic_phase_timer #(
        .PRESCALE    (P),
        .RED_TICKS   (RT),
        .GREEN_TICKS (GT),
        .YELLOW_TICKS(YT),
        .MIN_GREEN   (MG),
        .WAIT_MAX    (WM),
        .CW          (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .light    (light),
        .ped_req  (ped_req),
        .advance  (advance),
        .ped_ack  (ped_ack),
        .remaining(remaining),
        .err      (err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int rem;
        bit errv;
    } stat_t;

    stat_t statQ[$];
    int    advQ[$];
    int    ackQ[$];

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    bit stopMon = 1'b0;
    bit lastAdv = 1'b0;

    // Reference model: each phase is an anchor cycle plus a tick count, from
    // which the advance deadline and the remaining value follow directly.
    bit         mFresh   = 1'b1;
    bit         mPend    = 1'b0;
    bit         mReqPrev = 1'b0;
    bit         mErr     = 1'b0;
    logic [2:0] mLightQ  = 3'b000;
    int         mAnchor  = 0;
    int         mTicks   = 0;
    int         mRemNow  = 0;

    function automatic int phaseTicks(input logic [2:0] code);
        case (code)
            RED:     return RT;
            GREEN:   return GT;
            YELLOW:  return YT;
            default: return RT;
        endcase
    endfunction

    function automatic logic [2:0] nextLight(input logic [2:0] code);
        case (code)
            RED:     return GREEN;
            GREEN:   return YELLOW;
            default: return RED;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d",
                     name, cyc, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: condition not reached within budget at cycle %0d, got 0 expected 1",
                 name, cyc);
    endtask

    task automatic modelCycle(input int c, input bit r, input logic [2:0] l, input bit req);
        int    advAt;
        int    rem;
        bit    counting;
        bit    load;
        bit    timeout;
        bit    ack;
        bit    shorten;
        stat_t s;
        if (r) begin
            mFresh   = 1'b1;
            mPend    = 1'b0;
            mReqPrev = 1'b0;
            mErr     = 1'b0;
            mRemNow  = 0;
            return;
        end
        advAt    = mAnchor + mTicks * P + 1;
        counting = !mFresh && (c > mAnchor) && (c < advAt);
        rem      = counting ? (mTicks - (c - mAnchor - 1) / P) : 0;
        load     = mFresh || ((c > advAt) && ((l != mLightQ) || (c == advAt + WM)));
        timeout  = !mFresh && (c == advAt + WM) && (l == mLightQ);
        ack      = load && (l == RED) && mPend;
        shorten  = counting && mPend && (l == GREEN) && (rem > MG);

        s.cyc  = c;
        s.rem  = rem;
        s.errv = mErr;
        statQ.push_back(s);
        if (!mFresh && (c == advAt)) advQ.push_back(c);
        if (ack) ackQ.push_back(c);
        mRemNow = rem;

        if (load) begin
            mAnchor = c;
            mTicks  = phaseTicks(l);
            mLightQ = l;
            mFresh  = 1'b0;
        end else if (shorten) begin
            mAnchor = c;
            mTicks  = MG;
        end
        if (timeout) mErr = 1'b1;
        if (ack) mPend = 1'b0;
        if (req && !mReqPrev) mPend = 1'b1;
        mReqPrev = req;
    endtask

    // One clock cycle of stimulus. mode selects how the light FSM reacts to
    // an advance seen in the previous cycle: 0 steps, 1 ignores, 2 glitches.
    task automatic applyStimulus(input bit r, input bit req, input int mode);
        @(negedge clk);
        lastAdv = (advance === 1'b1);
        @(posedge clk);
        #1;
        cyc++;
        if ((rst === 1'b0) && lastAdv) begin
            if (mode == 0) light = nextLight(light);
            else if (mode == 2) light = 3'b110;
        end
        if (r && (rst === 1'b0)) begin
            rst = 1'b1;
            #1;
            checkOutput("resetAdvance", advance, 0);
            checkOutput("resetPedAck", ped_ack, 0);
            checkOutput("resetRemaining", remaining, 0);
            checkOutput("resetErr", err, 0);
        end else begin
            rst = r;
        end
        ped_req = req;
        modelCycle(cyc, r, light, req);
    endtask

    // Monitor: compares the DUT against expectations queued for this cycle.
    initial begin
        stat_t s;
        forever begin
            @(negedge clk);
            if (!stopMon && (rst === 1'b0)) begin
                if (statQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL statQueue at cycle %0d: got empty queue, expected an entry", cyc);
                end else begin
                    s = statQ.pop_front();
                    checkOutput("remaining", remaining, s.rem);
                    checkOutput("err", err, s.errv);
                end
                if ((advQ.size() > 0) && (advQ[0] == cyc)) begin
                    void'(advQ.pop_front());
                    checkOutput("advancePulse", advance, 1);
                end else begin
                    checkOutput("advanceIdle", advance, 0);
                end
                if ((ackQ.size() > 0) && (ackQ[0] == cyc)) begin
                    void'(ackQ.pop_front());
                    checkOutput("pedAckPulse", ped_ack, 1);
                end else begin
                    checkOutput("pedAckIdle", ped_ack, 0);
                end
            end
        end
    end

    // Main sequence: directed scenarios, then a randomized run.
    initial begin
        int budget;
        bit rq;
        int rstLeft;
        int mode;

        rst     = 1'b1;
        light   = RED;
        ped_req = 1'b0;

        $display("[TB] start");
        repeat (3) applyStimulus(1, 0, 0);

        // Reset release on RED, then free run over three full light cycles.
        repeat (130) applyStimulus(0, 0, 0);

        // Press at the start of a full GREEN: shortened, acked at next RED.
        budget = 0;
        while (!((light == GREEN) && (mRemNow == 4)) && (budget < 200)) begin
            applyStimulus(0, 0, 0);
            budget++;
        end
        if (budget >= 200) reportTimeout("reachGreenFull");
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        repeat (60) applyStimulus(0, 0, 0);

        // Press with GREEN already at its last tick, then again during RED.
        budget = 0;
        while (!((light == GREEN) && (mRemNow == 1)) && (budget < 200)) begin
            applyStimulus(0, 0, 0);
            budget++;
        end
        if (budget >= 200) reportTimeout("reachGreenLast");
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        repeat (30) applyStimulus(0, 0, 0);
        budget = 0;
        while (!((light == RED) && (mRemNow == 2)) && (budget < 200)) begin
            applyStimulus(0, 0, 0);
            budget++;
        end
        if (budget >= 200) reportTimeout("reachRedMid");
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        repeat (80) applyStimulus(0, 0, 0);

        // Light FSM stops responding: err latches and timing carries on.
        budget = 0;
        while (!mErr && (budget < 200)) begin
            applyStimulus(0, 0, 1);
            budget++;
        end
        if (budget >= 200) reportTimeout("reachErr");
        repeat (20) applyStimulus(0, 0, 1);
        repeat (40) applyStimulus(0, 0, 2);
        repeat (60) applyStimulus(0, 0, 0);

        // Reset mid-RED with a request pending: request must be forgotten.
        budget = 0;
        while (!((light == RED) && (mRemNow == 3)) && (budget < 200)) begin
            applyStimulus(0, 0, 0);
            budget++;
        end
        if (budget >= 200) reportTimeout("reachRedFull");
        applyStimulus(0, 1, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        repeat (60) applyStimulus(0, 0, 0);

        // Randomized run: button toggles, unresponsive/glitching FSM, resets.
        rq      = 1'b0;
        rstLeft = 0;
        repeat (1500) begin
            if ($urandom_range(0, 9) == 0) rq = ~rq;
            if (rstLeft > 0) rstLeft--;
            else if ($urandom_range(0, 599) == 0) rstLeft = $urandom_range(1, 3);
            if ($urandom_range(0, 7) == 0) mode = 1;
            else if ($urandom_range(0, 15) == 0) mode = 2;
            else mode = 0;
            applyStimulus(rstLeft > 0, rq, mode);
        end
        applyStimulus(0, 0, 0);

        @(negedge clk);
        #1;
        stopMon = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
